// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM encoding and width helper for the sequential multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - combinational carry-lookahead adder, 4-bit lookahead groups with rippled group carries
module cla_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_c;
  logic [NG:0]      w_gc;

  assign w_g = x & y;
  assign w_p = x ^ y;

  // Sum-of-products carry into bit hi, given carry c0 entering bit lo of the same group.
  function automatic logic la_carry(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                    input logic c0, input int lo, input int hi);
    logic c;
    logic pr;
    c = 1'b0;
    for (int j = lo; j < hi; j++) begin
      pr = 1'b1;
      for (int m = j + 1; m < hi; m++) pr = pr & p[m];
      c = c | (g[j] & pr);
    end
    pr = 1'b1;
    for (int m = lo; m < hi; m++) pr = pr & p[m];
    return c | (c0 & pr);
  endfunction

  always_comb begin
    w_c     = '0;
    w_gc    = '0;
    w_gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      for (int i = 4 * k; i < ((4 * k + 4 < WIDTH) ? 4 * k + 4 : WIDTH); i++) begin
        w_c[i] = la_carry(w_g, w_p, w_gc[k], 4 * k, i);
      end
      w_gc[k+1] = la_carry(w_g, w_p, w_gc[k], 4 * k, (4 * k + 4 < WIDTH) ? 4 * k + 4 : WIDTH);
    end
  end

  assign sum  = w_p ^ w_c;
  assign cout = w_gc[NG];

endmodule

// File: rtl/seq_cla_multiplier.sv
// rtl/seq_cla_multiplier.sv - shift-and-add multiplier over one CLA adder, WIDTH iterations per product
// Optional two's-complement operands under SIGNED_MUL_EN (sign-magnitude around the unsigned core).
module seq_cla_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = clog2(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [2*WIDTH-1:0] r_product;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_add_sum;
  logic               w_add_cout;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_shift;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH-1:0]   w_a_op;
  logic [WIDTH-1:0]   w_b_op;
  logic               w_accept;
  logic               w_last;

  cla_adder #(.WIDTH(WIDTH)) u_cla (
    .x   (r_acc_hi),
    .y   (r_mcand),
    .cin (1'b0),
    .sum (w_add_sum),
    .cout(w_add_cout)
  );

  // Carry-out lands in acc_hi's MSB after the shift, so the accumulator never overflows.
  assign w_sum       = r_mplier[0] ? {w_add_cout, w_add_sum} : {1'b0, r_acc_hi};
  assign w_acc_shift = (2*WIDTH)'({w_sum, r_acc_lo} >> 1);
  assign w_accept    = (r_state == IDLE) && start;
  assign w_last      = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));

`ifdef SIGNED_MUL_EN
  logic r_neg;

  assign w_a_op   = a[WIDTH-1] ? -a : a;
  assign w_b_op   = b[WIDTH-1] ? -b : b;
  assign w_result = r_neg ? -w_acc_shift : w_acc_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_neg <= 1'b0;
    else if (w_accept) r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  assign w_a_op   = a;
  assign w_b_op   = b;
  assign w_result = w_acc_shift;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mcand  <= w_a_op;
        r_mplier <= w_b_op;
        r_acc_hi <= '0;
        r_acc_lo <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_state == RUN) begin
        {r_acc_hi, r_acc_lo} <= w_acc_shift;
        r_mplier             <= r_mplier >> 1;
        r_cnt                <= r_cnt + CW'(1);
        if (w_last) begin
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_product <= w_result;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
